// File: rtl/dphy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dphy_pkg
// Description : Shared types and constants for the D-PHY HS transmit
//               sequencer: state enum, HS leader byte, default timing
//               windows and small elaboration-time helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package dphy_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLK_PRE   = 3'd1,
        DATA_PREP = 3'd2,
        SYNC      = 3'd3,
        PAYLOAD   = 3'd4,
        TRAIL     = 3'd5,
        CLK_POST  = 3'd6
    } dphy_state_e;

    localparam logic [7:0]  DPHY_SYNC_BYTE  = 8'hB8;

    localparam int unsigned DEF_T_CLK_PRE  = 8;
    localparam int unsigned DEF_T_HS_PREP  = 4;
    localparam int unsigned DEF_T_HS_TRAIL = 4;
    localparam int unsigned DEF_T_CLK_POST = 8;
    localparam int unsigned DEF_LEN_W      = 16;

    // A timing window of 0 still occupies one cycle.
    function automatic int unsigned dphy_eff(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned dphy_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dphy_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : dphy_seq_timer
// Description : Loadable down-counter with zero flag. The sequencer loads
//               (window - 1) on entry to a timed state and leaves the state
//               in the cycle where zero is high.
// Revision    : 1.0 - initial release
// Ports       : sysclk   - clock
//               reset_n  - asynchronous active-low reset
//               load     - load load_val this cycle (has priority)
//               load_val - value to load
//               zero     - count is zero
// ============================================================================
module dphy_seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         sysclk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dphy_hs_seq.sv
`default_nettype none
// ============================================================================
// Module      : dphy_hs_seq
// Description : Single-lane MIPI D-PHY HS transmit sequencer. Runs the
//               LP->HS->LP timing windows, inserts the sync byte, streams
//               payload from a byte source and drives the PHY lane enables.
//               All outputs are registered and reflect the state being
//               entered, so each output is aligned with the state register.
// Revision    : 1.0 - initial release
// Options     : DPHY_CONT_CLK_EN - continuous HS clock; hs_clk_en is held
//               high after reset and CLK_PRE / CLK_POST are skipped.
// Ports       : sysclk, reset_n          - clock, async active-low reset
//               tx_req, tx_len, tx_ack   - burst request / length / accept
//               src_data, src_valid,
//               src_ready                - payload byte source
//               hs_clk_en, hs_data_en    - PHY lane enables
//               pkt_en, byte_data        - byte stream to the serializer
//               busy, done, underrun     - status
// ============================================================================
module dphy_hs_seq
    import dphy_pkg::*;
#(
    parameter int unsigned T_CLK_PRE  = DEF_T_CLK_PRE,
    parameter int unsigned T_HS_PREP  = DEF_T_HS_PREP,
    parameter int unsigned T_HS_TRAIL = DEF_T_HS_TRAIL,
    parameter int unsigned T_CLK_POST = DEF_T_CLK_POST,
    parameter logic [7:0]  SYNC_BYTE  = DPHY_SYNC_BYTE,
    parameter int unsigned LEN_W      = DEF_LEN_W
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic             tx_req,
    input  logic [LEN_W-1:0] tx_len,
    output logic             tx_ack,
    input  logic [7:0]       src_data,
    input  logic             src_valid,
    output logic             src_ready,
    output logic             hs_clk_en,
    output logic             hs_data_en,
    output logic             pkt_en,
    output logic [7:0]       byte_data,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    localparam int unsigned CNT_W = dphy_max(8, LEN_W);

    localparam logic [CNT_W-1:0] PREP_LD  = CNT_W'(dphy_eff(T_HS_PREP) - 1);
    localparam logic [CNT_W-1:0] TRAIL_LD = CNT_W'(dphy_eff(T_HS_TRAIL) - 1);
`ifndef DPHY_CONT_CLK_EN
    localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(dphy_eff(T_CLK_PRE) - 1);
    localparam logic [CNT_W-1:0] POST_LD  = CNT_W'(dphy_eff(T_CLK_POST) - 1);
`endif

    dphy_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             last_msb_q, last_msb_d;
    logic             underrun_q, underrun_d;
    logic             tx_ack_q, tx_ack_d;
    logic             done_q, done_d;
    logic             src_ready_q, src_ready_d;
    logic             pkt_en_q, pkt_en_d;
    logic [7:0]       byte_q, byte_d;
    logic             hs_clk_en_q, hs_clk_en_d;
    logic             hs_data_en_q, hs_data_en_d;
    logic             busy_q, busy_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_zero;
    logic [7:0]       payload_byte;

    dphy_seq_timer #(
        .W (CNT_W)
    ) u_timer (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    // HS has no idle symbol: a missing source byte is replaced by 0x00.
    assign payload_byte = src_valid ? src_data : 8'h00;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        last_msb_d   = last_msb_q;
        underrun_d   = underrun_q;
        tx_ack_d     = 1'b0;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        // Next-state: each timed state loads the timer on entry and
        // leaves when it has counted down to zero.
        case (state_q)
            IDLE: begin
                if (tx_req) begin
                    tx_ack_d   = 1'b1;
                    len_d      = tx_len;
                    underrun_d = 1'b0;
                    tmr_load   = 1'b1;
`ifdef DPHY_CONT_CLK_EN
                    state_d      = DATA_PREP;
                    tmr_load_val = PREP_LD;
`else
                    state_d      = CLK_PRE;
                    tmr_load_val = PRE_LD;
`endif
                end
            end
            CLK_PRE: begin
                if (tmr_zero) begin
                    state_d      = DATA_PREP;
                    tmr_load     = 1'b1;
                    tmr_load_val = PREP_LD;
                end
            end
            DATA_PREP: begin
                if (tmr_zero) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                tmr_load = 1'b1;
                if (len_q != '0) begin
                    state_d      = PAYLOAD;
                    tmr_load_val = CNT_W'(len_q) - CNT_W'(1);
                end else begin
                    state_d      = TRAIL;
                    tmr_load_val = TRAIL_LD;
                end
            end
            PAYLOAD: begin
                if (tmr_zero) begin
                    state_d      = TRAIL;
                    tmr_load     = 1'b1;
                    tmr_load_val = TRAIL_LD;
                end
            end
            TRAIL: begin
                if (tmr_zero) begin
`ifdef DPHY_CONT_CLK_EN
                    state_d = IDLE;
                    done_d  = 1'b1;
`else
                    state_d      = CLK_POST;
                    tmr_load     = 1'b1;
                    tmr_load_val = POST_LD;
`endif
                end
            end
            CLK_POST: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs for the state being entered.
        src_ready_d  = 1'b0;
        pkt_en_d     = 1'b0;
        byte_d       = 8'h00;
        hs_data_en_d = 1'b0;
        case (state_d)
            DATA_PREP: begin
                hs_data_en_d = 1'b1;
            end
            SYNC: begin
                hs_data_en_d = 1'b1;
                pkt_en_d     = 1'b1;
                byte_d       = SYNC_BYTE;
                last_msb_d   = SYNC_BYTE[7];
            end
            PAYLOAD: begin
                hs_data_en_d = 1'b1;
                pkt_en_d     = 1'b1;
                src_ready_d  = 1'b1;
                byte_d       = payload_byte;
                last_msb_d   = payload_byte[7];
                if (!src_valid) begin
                    underrun_d = 1'b1;
                end
            end
            TRAIL: begin
                // HS-trail: drive the complement of the final bit.
                hs_data_en_d = 1'b1;
                byte_d       = last_msb_q ? 8'h00 : 8'hFF;
            end
            default: begin
            end
        endcase

        busy_d = (state_d != IDLE);
`ifdef DPHY_CONT_CLK_EN
        hs_clk_en_d = 1'b1;
`else
        hs_clk_en_d = (state_d != IDLE);
`endif
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            last_msb_q   <= 1'b0;
            underrun_q   <= 1'b0;
            tx_ack_q     <= 1'b0;
            done_q       <= 1'b0;
            src_ready_q  <= 1'b0;
            pkt_en_q     <= 1'b0;
            byte_q       <= 8'h00;
            hs_clk_en_q  <= 1'b0;
            hs_data_en_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            last_msb_q   <= last_msb_d;
            underrun_q   <= underrun_d;
            tx_ack_q     <= tx_ack_d;
            done_q       <= done_d;
            src_ready_q  <= src_ready_d;
            pkt_en_q     <= pkt_en_d;
            byte_q       <= byte_d;
            hs_clk_en_q  <= hs_clk_en_d;
            hs_data_en_q <= hs_data_en_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_ack     = tx_ack_q;
    assign done       = done_q;
    assign src_ready  = src_ready_q;
    assign pkt_en     = pkt_en_q;
    assign byte_data  = byte_q;
    assign hs_clk_en  = hs_clk_en_q;
    assign hs_data_en = hs_data_en_q;
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule
`default_nettype wire
